// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone arbiter in front of the SDRAM controller slave port.
// Round-robin grant held for a whole bus cycle, with a stall watchdog.
module wb_sdram_arbiter #(
  parameter int dw     = 32,
  parameter int APP_AW = 26,
  parameter int TMO    = 255
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic              sdr_init_done,
  input  logic              m0_wb_cyc_i,
  input  logic              m0_wb_stb_i,
  input  logic              m0_wb_we_i,
  input  logic [APP_AW-1:0] m0_wb_addr_i,
  input  logic [dw-1:0]     m0_wb_dat_i,
  input  logic [dw/8-1:0]   m0_wb_sel_i,
  input  logic [2:0]        m0_wb_cti_i,
  output logic              m0_wb_ack_o,
  output logic              m0_wb_err_o,
  output logic [dw-1:0]     m0_wb_dat_o,
  input  logic              m1_wb_cyc_i,
  input  logic              m1_wb_stb_i,
  input  logic              m1_wb_we_i,
  input  logic [APP_AW-1:0] m1_wb_addr_i,
  input  logic [dw-1:0]     m1_wb_dat_i,
  input  logic [dw/8-1:0]   m1_wb_sel_i,
  input  logic [2:0]        m1_wb_cti_i,
  output logic              m1_wb_ack_o,
  output logic              m1_wb_err_o,
  output logic [dw-1:0]     m1_wb_dat_o,
  output logic              wb_cyc_i,
  output logic              wb_stb_i,
  output logic              wb_we_i,
  output logic [APP_AW-1:0] wb_addr_i,
  output logic [dw-1:0]     wb_dat_i,
  output logic [dw/8-1:0]   wb_sel_i,
  output logic [2:0]        wb_cti_i,
  input  logic              wb_ack_o,
  input  logic [dw-1:0]     wb_dat_o,
  output logic [1:0]        gnt_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2, ABORT = 2'd3} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TMO - 1);

  state_t      state_r, state_nxt;
  logic        last_r, last_nxt;
  logic        owner_r, owner_nxt;
  logic [15:0] wdog_r, wdog_nxt;
  logic        req0_s, req1_s, act0_s, act1_s, own_cyc_s, pick_s;

  assign req0_s    = m0_wb_cyc_i & m0_wb_stb_i;
  assign req1_s    = m1_wb_cyc_i & m1_wb_stb_i;
  assign act0_s    = (state_r == GNT0) & m0_wb_cyc_i;
  assign act1_s    = (state_r == GNT1) & m1_wb_cyc_i;
  assign own_cyc_s = (state_r == GNT1) ? m1_wb_cyc_i : m0_wb_cyc_i;
  // On a tie the master that was not served last wins.
  assign pick_s    = (req0_s & req1_s) ? ~last_r : req1_s;

  // State, round-robin pointer, owner and watchdog registers
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_r <= IDLE;
      last_r  <= 1'b1;
      owner_r <= 1'b0;
      wdog_r  <= 16'd0;
    end else begin
      state_r <= state_nxt;
      last_r  <= last_nxt;
      owner_r <= owner_nxt;
      wdog_r  <= wdog_nxt;
    end
  end

  // Next-state logic: arbitration, release, watchdog timeout
  always_comb begin
    state_nxt = state_r;
    last_nxt  = last_r;
    owner_nxt = owner_r;
    wdog_nxt  = wdog_r;
    case (state_r)
      IDLE: begin
        if (sdr_init_done && (req0_s || req1_s)) begin
          owner_nxt = pick_s;
          wdog_nxt  = 16'd0;
          state_nxt = pick_s ? GNT1 : GNT0;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT0, GNT1: begin
        if (!own_cyc_s) begin
          state_nxt = IDLE;
          last_nxt  = owner_r;
        end else if (wb_ack_o) begin
          wdog_nxt = 16'd0;
        end else if (wb_stb_i) begin
          wdog_nxt = wdog_r + 16'd1;
          // The stalled cycle that brings the count to TMO is the last one allowed.
          if (wdog_r >= TMO_LAST) begin
            state_nxt = ABORT;
          end else begin
            state_nxt = state_r;
          end
        end else begin
          wdog_nxt = wdog_r;
        end
      end
      ABORT: begin
        state_nxt = IDLE;
        last_nxt  = owner_r;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Slave-side mux, ack/err routing and grant vector
  always_comb begin
    wb_cyc_i    = 1'b0;
    wb_stb_i    = 1'b0;
    wb_we_i     = 1'b0;
    wb_addr_i   = '0;
    wb_dat_i    = '0;
    wb_sel_i    = '0;
    wb_cti_i    = 3'd0;
    m0_wb_ack_o = 1'b0;
    m1_wb_ack_o = 1'b0;
    if (act0_s) begin
      wb_cyc_i    = 1'b1;
      wb_stb_i    = m0_wb_stb_i;
      wb_we_i     = m0_wb_we_i;
      wb_addr_i   = m0_wb_addr_i;
      wb_dat_i    = m0_wb_dat_i;
      wb_sel_i    = m0_wb_sel_i;
      wb_cti_i    = m0_wb_cti_i;
      m0_wb_ack_o = wb_ack_o;
    end else if (act1_s) begin
      wb_cyc_i    = 1'b1;
      wb_stb_i    = m1_wb_stb_i;
      wb_we_i     = m1_wb_we_i;
      wb_addr_i   = m1_wb_addr_i;
      wb_dat_i    = m1_wb_dat_i;
      wb_sel_i    = m1_wb_sel_i;
      wb_cti_i    = m1_wb_cti_i;
      m1_wb_ack_o = wb_ack_o;
    end else begin
      wb_cyc_i = 1'b0;
    end
    m0_wb_err_o = (state_r == ABORT) & ~owner_r;
    m1_wb_err_o = (state_r == ABORT) & owner_r;
    case (state_r)
      IDLE:    gnt_o = 2'b00;
      GNT0:    gnt_o = 2'b01;
      GNT1:    gnt_o = 2'b10;
      ABORT:   gnt_o = {owner_r, ~owner_r};
      default: gnt_o = 2'b00;
    endcase
  end

  assign m0_wb_dat_o = (state_r != IDLE) ? wb_dat_o : '0;
  assign m1_wb_dat_o = (state_r != IDLE) ? wb_dat_o : '0;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Bench for wb_sdram_arbiter: directed vector table, hand-written corner
// sequences, then random traffic checked against a transaction-level model.
module tb_wb_sdram_arbiter;
  localparam int DW  = 32;
  localparam int AW  = 26;
  localparam int TMO = 8;

  logic sys_clk = 1'b0;
  logic sys_resetn, sdr_init_done;
  logic m0_wb_cyc_i, m0_wb_stb_i, m0_wb_we_i, m0_wb_ack_o, m0_wb_err_o;
  logic [AW-1:0] m0_wb_addr_i;
  logic [DW-1:0] m0_wb_dat_i, m0_wb_dat_o;
  logic [3:0]    m0_wb_sel_i;
  logic [2:0]    m0_wb_cti_i;
  logic m1_wb_cyc_i, m1_wb_stb_i, m1_wb_we_i, m1_wb_ack_o, m1_wb_err_o;
  logic [AW-1:0] m1_wb_addr_i;
  logic [DW-1:0] m1_wb_dat_i, m1_wb_dat_o;
  logic [3:0]    m1_wb_sel_i;
  logic [2:0]    m1_wb_cti_i;
  logic wb_cyc_i, wb_stb_i, wb_we_i, wb_ack_o;
  logic [AW-1:0] wb_addr_i;
  logic [DW-1:0] wb_dat_i, wb_dat_o;
  logic [3:0]    wb_sel_i;
  logic [2:0]    wb_cti_i;
  logic [1:0]    gnt_o;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  wb_sdram_arbiter #(.dw(DW), .APP_AW(AW), .TMO(TMO)) dut (
    .sys_clk(sys_clk), .sys_resetn(sys_resetn), .sdr_init_done(sdr_init_done),
    .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_stb_i(m0_wb_stb_i), .m0_wb_we_i(m0_wb_we_i),
    .m0_wb_addr_i(m0_wb_addr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_sel_i(m0_wb_sel_i),
    .m0_wb_cti_i(m0_wb_cti_i), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
    .m0_wb_dat_o(m0_wb_dat_o),
    .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_stb_i(m1_wb_stb_i), .m1_wb_we_i(m1_wb_we_i),
    .m1_wb_addr_i(m1_wb_addr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_sel_i(m1_wb_sel_i),
    .m1_wb_cti_i(m1_wb_cti_i), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
    .m1_wb_dat_o(m1_wb_dat_o),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i),
    .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i), .wb_cti_i(wb_cti_i),
    .wb_ack_o(wb_ack_o), .wb_dat_o(wb_dat_o), .gnt_o(gnt_o)
  );

  typedef struct packed {
    logic init, c0, s0, c1, s1, ack;
    logic [1:0] gnt, bus, ackm, errm;
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [67:0] exp_slave(input logic [1:0] bus);
    if (bus[0])
      return {1'b1, m0_wb_stb_i, m0_wb_we_i, m0_wb_addr_i, m0_wb_dat_i, m0_wb_sel_i, m0_wb_cti_i};
    else if (bus[1])
      return {1'b1, m1_wb_stb_i, m1_wb_we_i, m1_wb_addr_i, m1_wb_dat_i, m1_wb_sel_i, m1_wb_cti_i};
    else
      return 68'd0;
  endfunction

  // bus: one-hot master expected on the controller pins (00 = pins idle)
  task automatic check_all(input string name, input logic [1:0] gnt, input logic [1:0] bus,
                           input logic [1:0] ackm, input logic [1:0] errm);
    check({name, " gnt"}, 128'(gnt_o), 128'(gnt));
    check({name, " slave"},
          128'({wb_cyc_i, wb_stb_i, wb_we_i, wb_addr_i, wb_dat_i, wb_sel_i, wb_cti_i}),
          128'(exp_slave(bus)));
    check({name, " ack"}, 128'({m1_wb_ack_o, m0_wb_ack_o}), 128'(ackm));
    check({name, " err"}, 128'({m1_wb_err_o, m0_wb_err_o}), 128'(errm));
    check({name, " rdat"}, 128'({m1_wb_dat_o, m0_wb_dat_o}),
          (gnt != 2'b00) ? 128'({wb_dat_o, wb_dat_o}) : 128'd0);
  endtask

  task automatic drive(input logic init, input logic c0, input logic s0,
                       input logic c1, input logic s1, input logic ack);
    sdr_init_done = init;
    m0_wb_cyc_i = c0; m0_wb_stb_i = s0;
    m1_wb_cyc_i = c1; m1_wb_stb_i = s1;
    wb_ack_o = ack;
    wb_dat_o = $urandom();
  endtask

  // One cycle: drive just after the edge, check mid-cycle, advance.
  task automatic row(input string name, input logic init, input logic c0, input logic s0,
                     input logic c1, input logic s1, input logic ack,
                     input logic [1:0] gnt, input logic [1:0] bus,
                     input logic [1:0] ackm, input logic [1:0] errm);
    drive(init, c0, s0, c1, s1, ack);
    #4;
    check_all(name, gnt, bus, ackm, errm);
    @(posedge sys_clk); #1;
  endtask

  // Transaction-level reference: who owns the bus, whether it is being
  // aborted, who was served last, and how long the owner has been stalled.
  int m_owner, m_last, m_wait;
  bit m_abort;

  task automatic model_reset();
    m_owner = -1; m_last = 1; m_wait = 0; m_abort = 1'b0;
  endtask

  task automatic model_expect(output logic [1:0] gnt, output logic [1:0] bus,
                              output logic [1:0] ackm, output logic [1:0] errm);
    logic own_cyc;
    gnt = 2'b00; bus = 2'b00; ackm = 2'b00; errm = 2'b00;
    own_cyc = (m_owner == 1) ? m1_wb_cyc_i : m0_wb_cyc_i;
    if (m_owner >= 0) begin
      gnt[m_owner] = 1'b1;
      if (m_abort) errm[m_owner] = 1'b1;
      else if (own_cyc) begin
        bus[m_owner]  = 1'b1;
        ackm[m_owner] = wb_ack_o;
      end
    end
  endtask

  task automatic model_step();
    logic r0, r1, own_cyc, own_stb;
    r0 = m0_wb_cyc_i & m0_wb_stb_i;
    r1 = m1_wb_cyc_i & m1_wb_stb_i;
    own_cyc = (m_owner == 1) ? m1_wb_cyc_i : m0_wb_cyc_i;
    own_stb = (m_owner == 1) ? m1_wb_stb_i : m0_wb_stb_i;
    if (m_owner < 0) begin
      if (sdr_init_done && (r0 || r1)) begin
        m_owner = (r0 && r1) ? 1 - m_last : (r0 ? 0 : 1);
        m_wait = 0;
      end
    end else if (m_abort) begin
      m_last = m_owner; m_owner = -1; m_abort = 1'b0;
    end else if (!own_cyc) begin
      m_last = m_owner; m_owner = -1;
    end else if (wb_ack_o) begin
      m_wait = 0;
    end else if (own_stb) begin
      m_wait++;
      if (m_wait >= TMO) m_abort = 1'b1;
    end
  endtask

  vec_t tbl[18];

  initial begin
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};
    tbl[2]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,2'b00,2'b00};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00};
    tbl[4]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00};
    tbl[5]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b01,2'b00,2'b00};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b1, 2'b01,2'b01,2'b01,2'b00};
    tbl[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b01,2'b00,2'b00,2'b00};
    tbl[8]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00};
    tbl[9]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b10,2'b10,2'b10,2'b00};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b00,2'b00};
    tbl[11] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00};
    tbl[12] = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1, 2'b01,2'b01,2'b01,2'b00};
    tbl[13] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b01,2'b00,2'b00,2'b00};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0, 2'b00,2'b00,2'b00,2'b00};
    tbl[15] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b1, 2'b10,2'b10,2'b10,2'b00};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b10,2'b00,2'b00,2'b00};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,2'b00,2'b00};

    sys_resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    m0_wb_we_i = 1'b1; m0_wb_addr_i = 26'h0000100; m0_wb_dat_i = 32'hDEADBEEF;
    m0_wb_sel_i = 4'hF; m0_wb_cti_i = 3'b000;
    m1_wb_we_i = 1'b0; m1_wb_addr_i = 26'h0002000; m1_wb_dat_i = 32'h12345678;
    m1_wb_sel_i = 4'h3; m1_wb_cti_i = 3'b000;
    @(posedge sys_clk); #1;
    check_all("reset", 2'b00, 2'b00, 2'b00, 2'b00);
    sys_resetn = 1'b1;

    for (int i = 0; i < 18; i++)
      row($sformatf("vec%0d", i), tbl[i].init, tbl[i].c0, tbl[i].s0, tbl[i].c1, tbl[i].s1,
          tbl[i].ack, tbl[i].gnt, tbl[i].bus, tbl[i].ackm, tbl[i].errm);

    // Watchdog: m0 stalls TMO cycles, then one abort cycle, late ack dropped.
    row("tmo_arb", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < TMO; i++)
      row($sformatf("tmo_stall%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
          2'b01, 2'b01, 2'b00, 2'b00);
    row("tmo_abort", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01, 2'b00, 2'b00, 2'b01);
    row("tmo_idle", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00);

    // m1 now owns the bus: 4-beat burst with m0 waiting.
    for (int i = 0; i < 4; i++) begin
      m1_wb_cti_i = (i == 3) ? 3'b111 : 3'b010;
      row($sformatf("burst%0d", i), 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
          2'b10, 2'b10, 2'b10, 2'b00);
    end
    m1_wb_cti_i = 3'b000;
    row("burst_rel", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
    row("burst_gap", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    m0_wb_cti_i = 3'b010;
    row("m0_after", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);

    // Asynchronous reset in the middle of m0's burst.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #2;
    sys_resetn = 1'b0;
    #1;
    check_all("rst_async", 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge sys_clk); #1;
    check_all("rst_held", 2'b00, 2'b00, 2'b00, 2'b00);
    sys_resetn = 1'b1;
    m0_wb_cti_i = 3'b000;
    row("post_rst_idle", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
    row("post_rst_tie", 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00);

    // Random traffic against the reference model.
    sys_resetn = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge sys_clk); #1;
    sys_resetn = 1'b1;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [1:0] eg, eb, ea, ee;
      logic c0, c1;
      c0 = m0_wb_cyc_i ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
      c1 = m1_wb_cyc_i ? ($urandom_range(0, 5) != 0) : ($urandom_range(0, 3) == 0);
      drive(($urandom_range(0, 19) != 0),
            c0, c0 & ($urandom_range(0, 3) != 0),
            c1, c1 & ($urandom_range(0, 3) != 0),
            ((n % 60) >= 14) && ($urandom_range(0, 2) != 0));
      m0_wb_we_i = 1'($urandom()); m0_wb_addr_i = 26'($urandom()); m0_wb_dat_i = $urandom();
      m0_wb_sel_i = 4'($urandom()); m0_wb_cti_i = 3'($urandom());
      m1_wb_we_i = 1'($urandom()); m1_wb_addr_i = 26'($urandom()); m1_wb_dat_i = $urandom();
      m1_wb_sel_i = 4'($urandom()); m1_wb_cti_i = 3'($urandom());
      #4;
      model_expect(eg, eb, ea, ee);
      check_all($sformatf("rnd%0d", n), eg, eb, ea, ee);
      model_step();
      @(posedge sys_clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
